// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory combinationally
// and registers the returned word into IF/ID, with stall, redirect and end-of-program halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 13,
  parameter logic [31:0] NOP       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        desvio,
  input  logic [31:0] alvo_desvio,
  output logic [31:0] endereco,
  input  logic [31:0] instrucao,
  output logic [31:0] if_id_instrucao,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_mais4,
  output logic        if_id_valido,
  output logic        fim_programa,
  output logic [31:0] cont_busca
);

  typedef enum logic {FETCH, HALTED} state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);
  localparam logic [31:0] PC_INIT    = RESET_PC & ~32'h3;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] ifpc_reg, ifpc_next;
  logic [31:0] ifpc4_reg, ifpc4_next;
  logic        valido_reg, valido_next;
  logic [31:0] cont_reg, cont_next;

  logic [31:0] pc_mais4;
  logic        in_range;

  assign pc_mais4 = pc_reg + 32'd4;
  // Word-index compare keeps the bound exact for any MEM_WORDS.
  assign in_range = pc_reg[31:2] < WORD_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= FETCH;
      pc_reg     <= PC_INIT;
      instr_reg  <= NOP;
      ifpc_reg   <= 32'h0;
      ifpc4_reg  <= 32'h0;
      valido_reg <= 1'b0;
      cont_reg   <= 32'h0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      ifpc_reg   <= ifpc_next;
      ifpc4_reg  <= ifpc4_next;
      valido_reg <= valido_next;
      cont_reg   <= cont_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    ifpc_next   = ifpc_reg;
    ifpc4_next  = ifpc4_reg;
    valido_next = valido_reg;
    cont_next   = cont_reg;

    if (desvio) begin
      // Redirect wins over stall; the wrong-path word in IF/ID becomes a bubble.
      pc_next     = alvo_desvio & ~32'h3;
      instr_next  = NOP;
      valido_next = 1'b0;
      state_next  = FETCH;
    end else if (!stall) begin
      case (state_reg)
        FETCH: begin
          if (in_range) begin
            instr_next  = instrucao;
            ifpc_next   = pc_reg;
            ifpc4_next  = pc_mais4;
            valido_next = 1'b1;
            pc_next     = pc_mais4;
            cont_next   = cont_reg + 32'd1;
          end else begin
            state_next  = HALTED;
            instr_next  = NOP;
            valido_next = 1'b0;
          end
        end
        default: begin
          instr_next  = NOP;
          valido_next = 1'b0;
        end
      endcase
    end
  end

  assign endereco        = pc_reg;
  assign if_id_instrucao = instr_reg;
  assign if_id_pc        = ifpc_reg;
  assign if_id_pc_mais4  = ifpc4_reg;
  assign if_id_valido    = valido_reg;
  assign fim_programa    = (state_reg == HALTED);
  assign cont_busca      = cont_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: instruction memory returns 0xA000_0000 | address,
// so every captured word can be predicted from its fetch address.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        desvio;
  logic [31:0] alvo_desvio;
  logic [31:0] endereco;
  logic [31:0] instrucao;
  logic [31:0] if_id_instrucao;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_mais4;
  logic        if_id_valido;
  logic        fim_programa;
  logic [31:0] cont_busca;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(13),
    .NOP      (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .desvio         (desvio),
    .alvo_desvio    (alvo_desvio),
    .endereco       (endereco),
    .instrucao      (instrucao),
    .if_id_instrucao(if_id_instrucao),
    .if_id_pc       (if_id_pc),
    .if_id_pc_mais4 (if_id_pc_mais4),
    .if_id_valido   (if_id_valido),
    .fim_programa   (fim_programa),
    .cont_busca     (cont_busca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instrucao = 32'hA000_0000 | endereco;

  // Advance one rising edge; outputs are then sampled at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; desvio = 1'b0; alvo_desvio = 32'h0;
    #12;
    n_checks++; if (endereco !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", endereco, 32'h0); end
    n_checks++; if (if_id_instrucao !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", if_id_instrucao, 32'h0); end
    n_checks++; if (if_id_pc !== 32'h0 || if_id_pc_mais4 !== 32'h0) begin n_fail++; $display("FAIL reset_ifpc: got %h/%h want 0/0", if_id_pc, if_id_pc_mais4); end
    n_checks++; if ({if_id_valido, fim_programa} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", if_id_valido, fim_programa); end
    n_checks++; if (cont_busca !== 32'h0) begin n_fail++; $display("FAIL reset_cont: got %0d want 0", cont_busca); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: pc=%h valido=%b cont=%0d", endereco, if_id_valido, cont_busca);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] epc;
      epc = 32'(i) * 32'd4;
      step();
      n_checks++; if (if_id_pc !== epc) begin n_fail++; $display("FAIL seq_ifpc[%0d]: got %h want %h", i, if_id_pc, epc); end
      n_checks++; if (if_id_pc_mais4 !== epc + 32'd4) begin n_fail++; $display("FAIL seq_pc4[%0d]: got %h want %h", i, if_id_pc_mais4, epc + 32'd4); end
      n_checks++; if (if_id_instrucao !== (32'hA000_0000 | epc)) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", i, if_id_instrucao, 32'hA000_0000 | epc); end
      n_checks++; if (if_id_valido !== 1'b1) begin n_fail++; $display("FAIL seq_valido[%0d]: got %b want 1", i, if_id_valido); end
      n_checks++; if (cont_busca !== 32'(i + 1)) begin n_fail++; $display("FAIL seq_cont[%0d]: got %0d want %0d", i, cont_busca, i + 1); end
      $display("fetch: if_id_pc=%h instr=%h cont=%0d", if_id_pc, if_id_instrucao, cont_busca);
    end
    n_checks++; if (endereco !== 32'hC) begin n_fail++; $display("FAIL seq_pc: got %h want %h", endereco, 32'hC); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (endereco !== 32'hC) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", i, endereco, 32'hC); end
      n_checks++; if (if_id_pc !== 32'h8 || if_id_instrucao !== 32'hA000_0008) begin n_fail++; $display("FAIL stall_ifid[%0d]: got %h/%h want 8/a0000008", i, if_id_pc, if_id_instrucao); end
      n_checks++; if (cont_busca !== 32'd3 || if_id_valido !== 1'b1) begin n_fail++; $display("FAIL stall_cont[%0d]: got %0d/%b want 3/1", i, cont_busca, if_id_valido); end
      $display("stall: pc=%h if_id_pc=%h cont=%0d", endereco, if_id_pc, cont_busca);
    end
    stall = 1'b0;
    step();
    n_checks++; if (if_id_pc !== 32'hC || cont_busca !== 32'd4) begin n_fail++; $display("FAIL stall_resume: got %h/%0d want c/4", if_id_pc, cont_busca); end
    $display("resume: if_id_pc=%h cont=%0d", if_id_pc, cont_busca);
  endtask

  task automatic test_redirect();
    desvio = 1'b1; stall = 1'b1; alvo_desvio = 32'h0000_0013;
    step();
    desvio = 1'b0; stall = 1'b0;
    n_checks++; if (endereco !== 32'h10) begin n_fail++; $display("FAIL redir_pc: got %h want %h", endereco, 32'h10); end
    n_checks++; if (if_id_valido !== 1'b0 || if_id_instrucao !== 32'h0) begin n_fail++; $display("FAIL redir_flush: got %b/%h want 0/0", if_id_valido, if_id_instrucao); end
    n_checks++; if (if_id_pc !== 32'hC || cont_busca !== 32'd4) begin n_fail++; $display("FAIL redir_hold: got %h/%0d want c/4", if_id_pc, cont_busca); end
    $display("redirect: pc=%h valido=%b", endereco, if_id_valido);
    step();
    n_checks++; if (if_id_pc !== 32'h10 || if_id_valido !== 1'b1) begin n_fail++; $display("FAIL redir_fetch: got %h/%b want 10/1", if_id_pc, if_id_valido); end
    n_checks++; if (cont_busca !== 32'd5 || endereco !== 32'h14) begin n_fail++; $display("FAIL redir_next: got %0d/%h want 5/14", cont_busca, endereco); end
    $display("fetch: if_id_pc=%h valido=%b cont=%0d", if_id_pc, if_id_valido, cont_busca);
  endtask

  task automatic test_halt();
    int cycles = 0;
    while (fim_programa !== 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
    n_checks++; if (cycles !== 9) begin n_fail++; $display("FAIL halt_latency: got %0d want 9", cycles); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (fim_programa !== 1'b1) begin n_fail++; $display("FAIL halt_fim[%0d]: got %b want 1", i, fim_programa); end
      n_checks++; if (endereco !== 32'h34) begin n_fail++; $display("FAIL halt_pc[%0d]: got %h want %h", i, endereco, 32'h34); end
      n_checks++; if (if_id_valido !== 1'b0 || if_id_instrucao !== 32'h0) begin n_fail++; $display("FAIL halt_flush[%0d]: got %b/%h want 0/0", i, if_id_valido, if_id_instrucao); end
      n_checks++; if (cont_busca !== 32'd13 || if_id_pc !== 32'h30) begin n_fail++; $display("FAIL halt_cont[%0d]: got %0d/%h want 13/30", i, cont_busca, if_id_pc); end
      $display("halted: pc=%h fim=%b cont=%0d", endereco, fim_programa, cont_busca);
      step();
    end
  endtask

  task automatic test_halt_redirect();
    desvio = 1'b1; alvo_desvio = 32'h4;
    step();
    desvio = 1'b0;
    n_checks++; if (fim_programa !== 1'b0 || endereco !== 32'h4) begin n_fail++; $display("FAIL hredir_state: got %b/%h want 0/4", fim_programa, endereco); end
    n_checks++; if (if_id_valido !== 1'b0) begin n_fail++; $display("FAIL hredir_flush: got %b want 0", if_id_valido); end
    step();
    n_checks++; if (if_id_pc !== 32'h4 || if_id_valido !== 1'b1) begin n_fail++; $display("FAIL hredir_fetch: got %h/%b want 4/1", if_id_pc, if_id_valido); end
    n_checks++; if (cont_busca !== 32'd14 || if_id_instrucao !== 32'hA000_0004) begin n_fail++; $display("FAIL hredir_cont: got %0d/%h want 14/a0000004", cont_busca, if_id_instrucao); end
    $display("restart: if_id_pc=%h valido=%b cont=%0d", if_id_pc, if_id_valido, cont_busca);
  endtask

  task automatic test_back_to_back();
    desvio = 1'b1; alvo_desvio = 32'h8;
    step();
    alvo_desvio = 32'h22;
    step();
    desvio = 1'b0;
    n_checks++; if (endereco !== 32'h20 || if_id_valido !== 1'b0) begin n_fail++; $display("FAIL b2b_redir: got %h/%b want 20/0", endereco, if_id_valido); end
    step();
    n_checks++; if (if_id_pc !== 32'h20 || if_id_pc_mais4 !== 32'h24) begin n_fail++; $display("FAIL b2b_fetch: got %h/%h want 20/24", if_id_pc, if_id_pc_mais4); end
    n_checks++; if (cont_busca !== 32'd15) begin n_fail++; $display("FAIL b2b_cont: got %0d want 15", cont_busca); end
    $display("b2b: if_id_pc=%h cont=%0d", if_id_pc, cont_busca);
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (endereco !== 32'h0 || cont_busca !== 32'h0) begin n_fail++; $display("FAIL areset_pc: got %h/%0d want 0/0", endereco, cont_busca); end
    n_checks++; if (if_id_pc !== 32'h0 || if_id_pc_mais4 !== 32'h0 || if_id_instrucao !== 32'h0) begin n_fail++; $display("FAIL areset_ifid: got %h/%h/%h want 0/0/0", if_id_pc, if_id_pc_mais4, if_id_instrucao); end
    n_checks++; if ({if_id_valido, fim_programa} !== 2'b00) begin n_fail++; $display("FAIL areset_flags: got %b%b want 00", if_id_valido, fim_programa); end
    $display("async reset: pc=%h valido=%b cont=%0d", endereco, if_id_valido, cont_busca);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    step();
    n_checks++; if (if_id_pc !== 32'h0 || if_id_valido !== 1'b1 || cont_busca !== 32'd1) begin n_fail++; $display("FAIL areset_restart: got %h/%b/%0d want 0/1/1", if_id_pc, if_id_valido, cont_busca); end
    $display("post reset fetch: if_id_pc=%h cont=%0d", if_id_pc, cont_busca);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_halt_redirect();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
